// File: rtl/operand_compute_store.sv
// Sequential compute-and-store engine: walks an index over two operand arrays,
// registers each wrapped sum and commits it into an internal result memory.
module operand_compute_store #(
  parameter  int MEM_DEPTH = 8,
  parameter  int MEM_WIDTH = 32,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MEM_WIDTH-1:0] operand1_i,
  input  logic [MEM_WIDTH-1:0] operand2_i,
  output logic [AW-1:0]        operand1_addr_o,
  output logic [AW-1:0]        operand2_addr_o,
  output logic [MEM_WIDTH-1:0] result_o,
  output logic [AW-1:0]        result_addr_o,
  output logic                 result_valid_o,
  output logic                 done_o,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [MEM_WIDTH-1:0] rd_data_o
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(MEM_DEPTH - 1);

  state_t               state, state_nxt;
  logic [AW-1:0]        idx_p0, idx_nxt;
  logic [MEM_WIDTH-1:0] result_p1, result_nxt;
  logic [AW-1:0]        addr_p1, addr_nxt;
  logic                 vld_p1, vld_nxt;
  logic                 done_q;
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  // Unsigned add, carry out of the top bit is dropped.
  function automatic logic [MEM_WIDTH-1:0] add_wrap(input logic [MEM_WIDTH-1:0] a,
                                                    input logic [MEM_WIDTH-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (idx_p0 == LAST_IDX) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    idx_nxt    = idx_p0;
    result_nxt = result_p1;
    addr_nxt   = addr_p1;
    vld_nxt    = 1'b0;
    if (state == S_RUN) begin
      result_nxt = add_wrap(operand1_i, operand2_i);
      addr_nxt   = idx_p0;
      vld_nxt    = 1'b1;
      if (idx_p0 != LAST_IDX) idx_nxt = idx_p0 + 1'b1;
    end
  end

  // p0 -> p1: index issue to registered sum / write address
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_p0    <= '0;
      result_p1 <= '0;
      addr_p1   <= '0;
      vld_p1    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      idx_p0    <= idx_nxt;
      result_p1 <= result_nxt;
      addr_p1   <= addr_nxt;
      vld_p1    <= vld_nxt;
      done_q    <= (state == S_DONE);
    end
  end

  // p1 -> memory: commit of the registered sum
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (vld_p1) begin
      mem[addr_p1] <= result_p1;
    end
  end

  assign operand1_addr_o = idx_p0;
  assign operand2_addr_o = idx_p0;
  assign result_o        = result_p1;
  assign result_addr_o   = addr_p1;
  assign result_valid_o  = vld_p1;
  assign done_o          = done_q;
  assign rd_data_o       = mem[rd_addr_i];

endmodule

// File: tb/tb_operand_compute_store.sv
// Bench for operand_compute_store: table vectors, random passes against a
// per-index sum model, cycle timing, post-done stability and mid-run reset.
module tb_operand_compute_store;
  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  operand1, operand2;
  logic [AW-1:0] operand1_addr, operand2_addr;
  logic [W-1:0]  result;
  logic [AW-1:0] result_addr;
  logic          result_valid;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  logic [W-1:0] op1_mem [DEPTH];
  logic [W-1:0] op2_mem [DEPTH];
  logic [W-1:0] exp_mem [DEPTH];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl [16];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign operand1 = op1_mem[operand1_addr];
  assign operand2 = op2_mem[operand2_addr];

  operand_compute_store #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .operand1_i     (operand1),
    .operand2_i     (operand2),
    .operand1_addr_o(operand1_addr),
    .operand2_addr_o(operand2_addr),
    .result_o       (result),
    .result_addr_o  (result_addr),
    .result_valid_o (result_valid),
    .done_o         (done),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic read_all(input string tag, input bit zero);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      #1;
      chk($sformatf("%s.rd[%0d]", tag, i), rd_data, zero ? '0 : exp_mem[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".op1_addr"}, W'(operand1_addr), '0);
    chk({tag, ".op2_addr"}, W'(operand2_addr), '0);
    chk({tag, ".result"}, result, '0);
    chk({tag, ".res_addr"}, W'(result_addr), '0);
    chk({tag, ".valid"}, W'(result_valid), '0);
    chk({tag, ".done"}, W'(done), '0);
    read_all(tag, 1'b1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs(tag);
  endtask

  // Release reset, then check the expected per-edge trajectory of a full pass.
  task automatic run_pass(input string tag);
    int nvld;
    int ea;
    logic [W-1:0] er;
    nvld = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      if (e > 0) @(posedge clk);
      #1;
      ea = (e < DEPTH - 1) ? e : DEPTH - 1;
      chk($sformatf("%s.e%0d.op_addr", tag, e), W'(operand1_addr), W'(ea));
      chk($sformatf("%s.e%0d.valid", tag, e), W'(result_valid), W'(e >= 1 && e <= DEPTH));
      chk($sformatf("%s.e%0d.done", tag, e), W'(done), W'(e >= DEPTH + 2));
      if (e == 0) begin
        ea = 0; er = '0;
      end else if (e <= DEPTH) begin
        ea = e - 1; er = exp_mem[e-1];
      end else begin
        ea = DEPTH - 1; er = exp_mem[DEPTH-1];
      end
      chk($sformatf("%s.e%0d.res_addr", tag, e), W'(result_addr), W'(ea));
      chk($sformatf("%s.e%0d.result", tag, e), result, er);
      if (result_valid) nvld++;
      if (e >= 2 && e - 2 < DEPTH) begin
        rd_addr = AW'(e - 2);
        #1;
        chk($sformatf("%s.e%0d.committed", tag, e), rd_data, exp_mem[e-2]);
      end
      if (e >= 1 && e - 1 < DEPTH) begin
        rd_addr = AW'(e - 1);
        #1;
        chk($sformatf("%s.e%0d.not_yet", tag, e), rd_data, '0);
      end
    end
    chk({tag, ".valid_cycles"}, W'(nvld), W'(DEPTH));
    read_all(tag, 1'b0);
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++) begin
      op1_mem[i] = $urandom;
      op2_mem[i] = $urandom;
      exp_mem[i] = op1_mem[i] + op2_mem[i];
    end
  endtask

  initial begin
    logic [W-1:0] held;
    rst_n   = 1'b0;
    rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      op1_mem[i] = '0;
      op2_mem[i] = '0;
      exp_mem[i] = '0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      tbl[i]         = '{a: W'(i + 1), b: W'(10 * i), exp: W'(11 * i + 1)};
      tbl[DEPTH + i] = tbl[i];
    end
    tbl[DEPTH + 3] = '{a: 32'hFFFF_FFFF, b: 32'd2, exp: 32'd1};
    tbl[DEPTH + 5] = '{a: 32'h8000_0000, b: 32'h8000_0000, exp: 32'd0};

    repeat (2) @(posedge clk);
    do_reset("reset");

    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        op1_mem[i] = tbl[p*DEPTH + i].a;
        op2_mem[i] = tbl[p*DEPTH + i].b;
        exp_mem[i] = tbl[p*DEPTH + i].exp;
      end
      run_pass($sformatf("table%0d", p));
      if (p == 0) begin
        held = result;
        load_random();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = tbl[i].exp;
        repeat (5) @(posedge clk);
        #1;
        chk("post_done.valid", W'(result_valid), '0);
        chk("post_done.done", W'(done), 32'd1);
        chk("post_done.op_addr", W'(operand2_addr), W'(DEPTH - 1));
        chk("post_done.res_addr", W'(result_addr), W'(DEPTH - 1));
        chk("post_done.result", result, held);
        read_all("post_done", 1'b0);
      end
      do_reset($sformatf("reset_after_table%0d", p));
    end

    for (int p = 0; p < 3; p++) begin
      load_random();
      run_pass($sformatf("random%0d", p));
      do_reset($sformatf("reset_after_random%0d", p));
    end

    load_random();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd_addr = '0;
    #1;
    chk("midrun.before_reset.rd0", rd_data, exp_mem[0]);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun.in_reset");
    load_random();
    run_pass("midrun.rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
